// File: rtl/usb_fs_rx_phy.sv
// Full-speed USB receive front end: 4x oversampling DPLL, NRZI decode, bit-unstuffing,
// SYNC/EOP framing, LSB-first byte assembly and long-SE0 bus-reset detection.
module usb_fs_rx_phy #(
  parameter int BITSTUFF_LIMIT = 6,
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int RESET_CYCLES   = 120
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  output logic       rx_pkt_start,
  output logic [7:0] rx_data,
  output logic       rx_data_put,
  output logic       rx_pkt_end,
  output logic       rx_pkt_valid,
  output logic       rx_bitstuff_err,
  output logic       rx_bus_reset
);
  localparam int OW = $clog2(BITSTUFF_LIMIT + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam logic [OW-1:0] STUFF_LIM = OW'(BITSTUFF_LIMIT);
  localparam logic [2:0]    SYNC_MIN  = 3'(SYNC_MIN_ZEROS);
  localparam logic [RW-1:0] RST_MAX   = RW'(RESET_CYCLES);
  localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {LS_SE0 = 2'd0, LS_J = 2'd1, LS_K = 2'd2} line_t;
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERR} state_t;

  logic          p_meta_q, p_sync_q, n_meta_q, n_sync_q;
  line_t         line_q, line_d, prev_q, prev_d;
  logic [1:0]    phase_q;
  logic          sample, nrzi_bit;
  state_t        state_q, state_d;
  logic [2:0]    aux_q, aux_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          valid_q, valid_d;
  logic          start_q, start_d, put_q, put_d, end_q, end_d, err_q, err_d;
  logic [RW-1:0] se0_cnt_q, se0_cnt_d;
  logic          busrst_q, busrst_d;

  // SE1 is not a legal bus state, so it simply keeps the last decoded state.
  always_comb begin
    line_d = line_q;
    if (p_sync_q && !n_sync_q)       line_d = LS_J;
    else if (!p_sync_q && n_sync_q)  line_d = LS_K;
    else if (!p_sync_q && !n_sync_q) line_d = LS_SE0;
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      p_meta_q <= 1'b1;
      p_sync_q <= 1'b1;
      n_meta_q <= 1'b0;
      n_sync_q <= 1'b0;
      line_q   <= LS_J;
      phase_q  <= 2'd0;
    end else begin
      p_meta_q <= usb_p_rx;
      p_sync_q <= p_meta_q;
      n_meta_q <= usb_n_rx;
      n_sync_q <= n_meta_q;
      line_q   <= line_d;
      phase_q  <= (line_d != line_q) ? 2'd0 : phase_q + 2'd1;
    end
  end

  assign sample   = (phase_q == 2'd2);
  assign nrzi_bit = (line_q == prev_q);

  // aux_q counts SYNC zeros, EOP SE0 bit times, or idle J bit times after an error.
  always_comb begin
    state_d  = state_q;
    aux_d    = aux_q;
    ones_d   = ones_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    prev_d   = prev_q;
    start_d  = 1'b0;
    put_d    = 1'b0;
    end_d    = 1'b0;
    err_d    = 1'b0;
    if (sample) begin
      prev_d = line_q;
      case (state_q)
        S_IDLE: begin
          if (line_q == LS_K && prev_q == LS_J) begin
            state_d = S_SYNC;
            aux_d   = 3'd1;
          end
        end
        S_SYNC: begin
          if (line_q == LS_SE0) begin
            state_d = S_IDLE;
          end else if (!nrzi_bit) begin
            if (aux_q != 3'd7) aux_d = aux_q + 3'd1;
          end else if (aux_q >= SYNC_MIN) begin
            state_d  = S_DATA;
            start_d  = 1'b1;
            valid_d  = 1'b0;
            ones_d   = '0;
            bitcnt_d = 3'd0;
            shift_d  = 8'h00;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          if (line_q == LS_SE0) begin
            state_d = S_EOP;
            aux_d   = 3'd1;
          end else if (ones_q == STUFF_LIM) begin
            if (nrzi_bit) begin
              err_d   = 1'b1;
              state_d = S_ERR;
              aux_d   = 3'd0;
            end else begin
              ones_d = '0;
            end
          end else begin
            shift_d  = {nrzi_bit, shift_q[7:1]};
            ones_d   = nrzi_bit ? ones_q + OW'(1) : '0;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              put_d  = 1'b1;
              data_d = {nrzi_bit, shift_q[7:1]};
            end
          end
        end
        S_EOP: begin
          if (line_q == LS_J) begin
            end_d   = 1'b1;
            valid_d = (bitcnt_q == 3'd0);
            state_d = S_IDLE;
          end else if (line_q == LS_K || aux_q == 3'd3) begin
            end_d   = 1'b1;
            valid_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            aux_d = aux_q + 3'd1;
          end
        end
        S_ERR: begin
          if (line_q != LS_J)      aux_d = 3'd0;
          else if (aux_q == 3'd7)  state_d = S_IDLE;
          else                     aux_d = aux_q + 3'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Bus reset runs on every cycle of SE0, independent of the packet FSM.
  always_comb begin
    se0_cnt_d = '0;
    busrst_d  = 1'b0;
    if (line_q == LS_SE0) begin
      se0_cnt_d = (se0_cnt_q == RST_MAX) ? se0_cnt_q : se0_cnt_q + RW'(1);
      busrst_d  = (se0_cnt_q == RST_LAST);
    end
  end

  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      aux_q     <= 3'd0;
      ones_q    <= '0;
      bitcnt_q  <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      prev_q    <= LS_J;
      start_q   <= 1'b0;
      put_q     <= 1'b0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
      se0_cnt_q <= '0;
      busrst_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aux_q     <= aux_d;
      ones_q    <= ones_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      prev_q    <= prev_d;
      start_q   <= start_d;
      put_q     <= put_d;
      end_q     <= end_d;
      err_q     <= err_d;
      se0_cnt_q <= se0_cnt_d;
      busrst_q  <= busrst_d;
    end
  end

  assign rx_pkt_start    = start_q;
  assign rx_data         = data_q;
  assign rx_data_put     = put_q;
  assign rx_pkt_end      = end_q;
  assign rx_pkt_valid    = valid_q;
  assign rx_bitstuff_err = err_q;
  assign rx_bus_reset    = busrst_q;
endmodule

// File: tb/tb_usb_fs_rx_phy.sv
// Bench for usb_fs_rx_phy: builds line symbol streams from byte/bit lists and checks
// received bytes, framing pulses and bus reset against expectations derived from those lists.
`timescale 1ns/1ps
module tb_usb_fs_rx_phy;
  localparam logic [1:0] S_SE0 = 2'd0, S_J = 2'd1, S_K = 2'd2;
  localparam int T = 20;

  logic clk_48mhz = 1'b0;
  logic reset, usb_p_rx, usb_n_rx;
  logic rx_pkt_start, rx_data_put, rx_pkt_end, rx_pkt_valid, rx_bitstuff_err, rx_bus_reset;
  logic [7:0] rx_data;

  usb_fs_rx_phy dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .usb_p_rx(usb_p_rx), .usb_n_rx(usb_n_rx),
    .rx_pkt_start(rx_pkt_start), .rx_data(rx_data), .rx_data_put(rx_data_put),
    .rx_pkt_end(rx_pkt_end), .rx_pkt_valid(rx_pkt_valid),
    .rx_bitstuff_err(rx_bitstuff_err), .rx_bus_reset(rx_bus_reset)
  );

  always #(T/2) clk_48mhz = ~clk_48mhz;

  int n_cmp = 0, n_fail = 0;
  int n_start = 0, n_end = 0, n_err = 0, n_busrst = 0;
  logic last_valid = 1'b0;
  time busrst_t = 0, end_t = 0;
  logic [7:0] got_bytes[$];
  logic [7:0] pkt_bytes[$];
  logic [7:0] exp_bytes[$];
  logic exp_valid;
  bit data_bits[$];
  logic [1:0] sym_q[$];

  // Event recorder: the only writer of the observed counters and byte log.
  always @(negedge clk_48mhz) begin
    if (rx_pkt_start) n_start++;
    if (rx_data_put) got_bytes.push_back(rx_data);
    if (rx_pkt_end) begin n_end++; last_valid = rx_pkt_valid; end_t = $time; end
    if (rx_bitstuff_err) n_err++;
    if (rx_bus_reset) begin n_busrst++; busrst_t = $time; end
  end

  task automatic drive(input logic [1:0] s);
    usb_p_rx = (s == S_J);
    usb_n_rx = (s == S_K);
  endtask

  task automatic bytes_to_bits();
    data_bits.delete();
    foreach (pkt_bytes[i]) for (int b = 0; b < 8; b++) data_bits.push_back(pkt_bytes[i][b]);
  endtask

  // Reference model: received bytes are the unstuffed data bits grouped 8 at a time.
  task automatic model_expect();
    for (int i = 0; i + 8 <= data_bits.size(); i += 8) begin
      logic [7:0] v;
      for (int k = 0; k < 8; k++) v[k] = data_bits[i+k];
      exp_bytes.push_back(v);
    end
    exp_valid = (data_bits.size() % 8 == 0);
  endtask

  // Appends idle J, SYNC, NRZI-coded data (optionally stuffed), SE0 SE0 J, idle J.
  task automatic encode(input bit stuff_en, input int idle_before, input int idle_after);
    logic [1:0] lvl;
    int ones;
    lvl = S_J;
    ones = 0;
    repeat (idle_before) sym_q.push_back(S_J);
    for (int i = 0; i < 8; i++) begin
      if (i != 7) lvl = (lvl == S_J) ? S_K : S_J;
      sym_q.push_back(lvl);
    end
    foreach (data_bits[i]) begin
      if (!data_bits[i]) begin lvl = (lvl == S_J) ? S_K : S_J; ones = 0; end
      else ones++;
      sym_q.push_back(lvl);
      if (stuff_en && ones == 6) begin
        lvl = (lvl == S_J) ? S_K : S_J;
        sym_q.push_back(lvl);
        ones = 0;
      end
    end
    sym_q.push_back(S_SE0);
    sym_q.push_back(S_SE0);
    sym_q.push_back(S_J);
    repeat (idle_after) sym_q.push_back(S_J);
  endtask

  // Plays sym_q with a given bit period; jitter moves each edge by up to one cycle.
  task automatic tx_run(input real period, input bit jit, input int max_syms);
    int j_prev, j, len, cur, nxt;
    j_prev = 0;
    for (int k = 0; k < sym_q.size() && k < max_syms; k++) begin
      cur = $rtoi(k * period + 0.5);
      nxt = $rtoi((k + 1) * period + 0.5);
      j = jit ? int'($urandom_range(0, 1)) : 0;
      len = nxt + j - cur - j_prev;
      if (len < 3 || len > 5) begin j = j_prev; len = nxt - cur; end
      drive(sym_q[k]);
      repeat (len) @(negedge clk_48mhz);
      j_prev = j;
    end
    sym_q.delete();
  endtask

  function automatic logic [15:0] crc16_from(input int from);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = from; i < pkt_bytes.size(); i++)
      for (int b = 0; b < 8; b++) begin
        fb = pkt_bytes[i][b] ^ c[0];
        c = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return ~c;
  endfunction

  task automatic test_reset();
    int s0, e0, b0;
    reset = 1'b1;
    drive(S_J);
    repeat (3) @(negedge clk_48mhz);
    n_cmp++;
    if ({rx_pkt_start, rx_data, rx_data_put, rx_pkt_end, rx_pkt_valid, rx_bitstuff_err, rx_bus_reset} !== 14'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want all zero", {rx_pkt_start, rx_data, rx_data_put, rx_pkt_end, rx_pkt_valid, rx_bitstuff_err, rx_bus_reset});
    end
    s0 = n_start; e0 = n_end; b0 = got_bytes.size();
    reset = 1'b0;
    repeat (40) @(negedge clk_48mhz);
    n_cmp++;
    if (n_start - s0 + n_end - e0 + got_bytes.size() - b0 !== 0) begin
      n_fail++; $display("FAIL reset_idle_quiet: got %0d events want 0", n_start - s0 + n_end - e0 + got_bytes.size() - b0);
    end
    $display("test_reset: done");
  endtask

  task automatic test_in_token();
    int s0, e0, b0;
    pkt_bytes = {8'h69, 8'h00, 8'h10};
    bytes_to_bits(); exp_bytes.delete(); model_expect();
    encode(1'b1, 4, 8);
    s0 = n_start; e0 = n_end; b0 = got_bytes.size();
    tx_run(4.0, 1'b0, 100000);
    repeat (12) @(negedge clk_48mhz);
    n_cmp++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL token_start: got %0d want 1", n_start - s0); end
    n_cmp++;
    if (got_bytes.size() - b0 !== exp_bytes.size()) begin
      n_fail++; $display("FAIL token_count: got %0d want %0d", got_bytes.size() - b0, exp_bytes.size());
    end else foreach (exp_bytes[i]) begin
      n_cmp++; if (got_bytes[b0+i] !== exp_bytes[i]) begin n_fail++; $display("FAIL token_byte%0d: got %h want %h", i, got_bytes[b0+i], exp_bytes[i]); end
    end
    n_cmp++; if (n_end - e0 !== 1 || last_valid !== 1'b1) begin n_fail++; $display("FAIL token_end: got ends=%0d valid=%b want 1/1", n_end - e0, last_valid); end
    repeat (20) @(negedge clk_48mhz);
    n_cmp++; if (rx_pkt_valid !== 1'b1) begin n_fail++; $display("FAIL token_valid_hold: got %b want 1", rx_pkt_valid); end
    $display("test_in_token: %0d bytes received", got_bytes.size() - b0);
  endtask

  task automatic test_stuffing();
    int e0, b0;
    logic [15:0] crc;
    pkt_bytes = {8'hC3, 8'hFF, 8'hFF};
    crc = crc16_from(1);
    pkt_bytes.push_back(crc[7:0]);
    pkt_bytes.push_back(crc[15:8]);
    bytes_to_bits(); exp_bytes.delete(); model_expect();
    encode(1'b1, 4, 8);
    e0 = n_end; b0 = got_bytes.size();
    tx_run(4.0, 1'b0, 100000);
    repeat (12) @(negedge clk_48mhz);
    n_cmp++;
    if (got_bytes.size() - b0 !== exp_bytes.size()) begin
      n_fail++; $display("FAIL stuff_count: got %0d want %0d", got_bytes.size() - b0, exp_bytes.size());
    end else foreach (exp_bytes[i]) begin
      n_cmp++; if (got_bytes[b0+i] !== exp_bytes[i]) begin n_fail++; $display("FAIL stuff_byte%0d: got %h want %h", i, got_bytes[b0+i], exp_bytes[i]); end
    end
    n_cmp++; if (n_end - e0 !== 1 || last_valid !== 1'b1) begin n_fail++; $display("FAIL stuff_end: got ends=%0d valid=%b want 1/1", n_end - e0, last_valid); end
    $display("test_stuffing: crc %h", crc);
  endtask

  task automatic test_bitstuff_err();
    int s0, e0, r0, b0;
    data_bits.delete();
    repeat (7) data_bits.push_back(1'b1);
    data_bits.push_back(1'b0); data_bits.push_back(1'b1); data_bits.push_back(1'b0);
    encode(1'b0, 4, 20);
    s0 = n_start; e0 = n_end; r0 = n_err; b0 = got_bytes.size();
    tx_run(4.0, 1'b0, 100000);
    repeat (12) @(negedge clk_48mhz);
    n_cmp++; if (n_err - r0 !== 1) begin n_fail++; $display("FAIL stuffErr_pulse: got %0d want 1", n_err - r0); end
    n_cmp++; if (n_end - e0 !== 0) begin n_fail++; $display("FAIL stuffErr_noend: got %0d want 0", n_end - e0); end
    n_cmp++; if (n_start - s0 !== 1 || got_bytes.size() - b0 !== 0) begin
      n_fail++; $display("FAIL stuffErr_framing: got starts=%0d bytes=%0d want 1/0", n_start - s0, got_bytes.size() - b0);
    end
    pkt_bytes = {8'($urandom), 8'($urandom)};
    bytes_to_bits(); exp_bytes.delete(); model_expect();
    encode(1'b1, 2, 6);
    e0 = n_end; b0 = got_bytes.size();
    tx_run(4.0, 1'b0, 100000);
    repeat (12) @(negedge clk_48mhz);
    n_cmp++;
    if (got_bytes.size() - b0 !== 2) begin
      n_fail++; $display("FAIL stuffErr_recover_count: got %0d want 2", got_bytes.size() - b0);
    end else foreach (exp_bytes[i]) begin
      n_cmp++; if (got_bytes[b0+i] !== exp_bytes[i]) begin n_fail++; $display("FAIL stuffErr_recover_byte%0d: got %h want %h", i, got_bytes[b0+i], exp_bytes[i]); end
    end
    n_cmp++; if (n_end - e0 !== 1 || last_valid !== 1'b1 || n_err - r0 !== 1) begin
      n_fail++; $display("FAIL stuffErr_recover_end: got ends=%0d valid=%b errs=%0d want 1/1/1", n_end - e0, last_valid, n_err - r0);
    end
    $display("test_bitstuff_err: done");
  endtask

  task automatic test_jitter();
    int e0, b0;
    real p;
    for (int r = 0; r < 2; r++) begin
      p = (r == 0) ? 3.9 : 4.1;
      pkt_bytes = {8'h69, 8'h00, 8'h10};
      bytes_to_bits(); exp_bytes.delete(); model_expect();
      encode(1'b1, 4, 8);
      e0 = n_end; b0 = got_bytes.size();
      tx_run(p, 1'b1, 100000);
      repeat (12) @(negedge clk_48mhz);
      n_cmp++;
      if (got_bytes.size() - b0 !== exp_bytes.size()) begin
        n_fail++; $display("FAIL jitter%0d_count: got %0d want %0d", r, got_bytes.size() - b0, exp_bytes.size());
      end else foreach (exp_bytes[i]) begin
        n_cmp++; if (got_bytes[b0+i] !== exp_bytes[i]) begin n_fail++; $display("FAIL jitter%0d_byte%0d: got %h want %h", r, i, got_bytes[b0+i], exp_bytes[i]); end
      end
      n_cmp++; if (n_end - e0 !== 1 || last_valid !== 1'b1) begin n_fail++; $display("FAIL jitter%0d_end: got ends=%0d valid=%b want 1/1", r, n_end - e0, last_valid); end
      $display("test_jitter: period %0.1f done", p);
    end
  endtask

  task automatic test_partial();
    int e0, b0;
    data_bits.delete();
    repeat (12) data_bits.push_back(1'($urandom));
    exp_bytes.delete(); model_expect();
    encode(1'b1, 4, 8);
    e0 = n_end; b0 = got_bytes.size();
    tx_run(4.0, 1'b0, 100000);
    repeat (12) @(negedge clk_48mhz);
    n_cmp++;
    if (got_bytes.size() - b0 !== 1) begin
      n_fail++; $display("FAIL partial_count: got %0d want 1", got_bytes.size() - b0);
    end else begin
      n_cmp++; if (got_bytes[b0] !== exp_bytes[0]) begin n_fail++; $display("FAIL partial_byte: got %h want %h", got_bytes[b0], exp_bytes[0]); end
    end
    n_cmp++; if (n_end - e0 !== 1 || last_valid !== 1'b0) begin n_fail++; $display("FAIL partial_end: got ends=%0d valid=%b want 1/0", n_end - e0, last_valid); end
    $display("test_partial: done");
  endtask

  task automatic test_random();
    int e0, b0, nb, extra;
    real p;
    bit jit;
    for (int it = 0; it < 8; it++) begin
      nb = $urandom_range(1, 5);
      extra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      case ($urandom_range(0, 2)) 0: p = 3.9; 1: p = 4.0; default: p = 4.1; endcase
      jit = 1'($urandom);
      pkt_bytes.delete();
      repeat (nb) pkt_bytes.push_back(8'($urandom));
      bytes_to_bits();
      repeat (extra) data_bits.push_back(1'($urandom));
      exp_bytes.delete(); model_expect();
      encode(1'b1, 3, 6);
      e0 = n_end; b0 = got_bytes.size();
      tx_run(p, jit, 100000);
      repeat (12) @(negedge clk_48mhz);
      n_cmp++;
      if (got_bytes.size() - b0 !== exp_bytes.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", it, got_bytes.size() - b0, exp_bytes.size());
      end else foreach (exp_bytes[i]) begin
        n_cmp++; if (got_bytes[b0+i] !== exp_bytes[i]) begin n_fail++; $display("FAIL rand%0d_byte%0d: got %h want %h", it, i, got_bytes[b0+i], exp_bytes[i]); end
      end
      n_cmp++; if (n_end - e0 !== 1 || last_valid !== exp_valid) begin n_fail++; $display("FAIL rand%0d_end: got ends=%0d valid=%b want 1/%b", it, n_end - e0, last_valid, exp_valid); end
      $display("test_random: it %0d bytes %0d extra %0d period %0.1f jit %0d", it, nb, extra, p, jit);
    end
  endtask

  task automatic test_back_to_back();
    int s0, e0, b0;
    exp_bytes.delete();
    for (int k = 0; k < 2; k++) begin
      pkt_bytes = {8'($urandom), 8'($urandom), 8'($urandom)};
      bytes_to_bits(); model_expect();
      encode(1'b1, (k == 0) ? 4 : 0, (k == 0) ? 0 : 6);
    end
    s0 = n_start; e0 = n_end; b0 = got_bytes.size();
    tx_run(4.0, 1'b0, 100000);
    repeat (12) @(negedge clk_48mhz);
    n_cmp++; if (n_start - s0 !== 2 || n_end - e0 !== 2) begin n_fail++; $display("FAIL b2b_framing: got starts=%0d ends=%0d want 2/2", n_start - s0, n_end - e0); end
    n_cmp++;
    if (got_bytes.size() - b0 !== 6) begin
      n_fail++; $display("FAIL b2b_count: got %0d want 6", got_bytes.size() - b0);
    end else foreach (exp_bytes[i]) begin
      n_cmp++; if (got_bytes[b0+i] !== exp_bytes[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_bytes[b0+i], exp_bytes[i]); end
    end
    n_cmp++; if (last_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", last_valid); end
    $display("test_back_to_back: done");
  endtask

  task automatic test_bus_reset();
    int r0, e0;
    time t0;
    longint lat;
    r0 = n_busrst; e0 = n_end;
    drive(S_SE0);
    t0 = $time;
    repeat (130) @(negedge clk_48mhz);
    drive(S_J);
    repeat (20) @(negedge clk_48mhz);
    lat = longint'((busrst_t - t0) / T);
    n_cmp++; if (n_busrst - r0 !== 1) begin n_fail++; $display("FAIL busrst_once: got %0d want 1", n_busrst - r0); end
    n_cmp++; if (n_busrst - r0 == 1 && (lat < 120 || lat > 124)) begin n_fail++; $display("FAIL busrst_time: got %0d cycles want 120..124", lat); end
    n_cmp++; if (n_end - e0 !== 0) begin n_fail++; $display("FAIL busrst_idle_noend: got %0d want 0", n_end - e0); end
    drive(S_SE0);
    repeat (100) @(negedge clk_48mhz);
    drive(S_J);
    repeat (20) @(negedge clk_48mhz);
    n_cmp++; if (n_busrst - r0 !== 1) begin n_fail++; $display("FAIL busrst_short_se0: got %0d want 1", n_busrst - r0); end
    $display("test_bus_reset: latency %0d cycles", lat);
  endtask

  task automatic test_bus_reset_mid_packet();
    int s0, e0, r0;
    pkt_bytes = {8'($urandom), 8'($urandom), 8'($urandom)};
    bytes_to_bits();
    encode(1'b1, 4, 4);
    s0 = n_start; e0 = n_end; r0 = n_busrst;
    tx_run(4.0, 1'b0, 4 + 8 + 16);
    drive(S_SE0);
    repeat (130) @(negedge clk_48mhz);
    drive(S_J);
    repeat (30) @(negedge clk_48mhz);
    n_cmp++; if (n_start - s0 !== 1 || n_end - e0 !== 1 || last_valid !== 1'b0) begin
      n_fail++; $display("FAIL midpkt_abort: got starts=%0d ends=%0d valid=%b want 1/1/0", n_start - s0, n_end - e0, last_valid);
    end
    n_cmp++; if (n_busrst - r0 !== 1 || end_t >= busrst_t) begin
      n_fail++; $display("FAIL midpkt_busrst: got pulses=%0d end_t=%0t rst_t=%0t want 1 pulse after end", n_busrst - r0, end_t, busrst_t);
    end
    $display("test_bus_reset_mid_packet: done");
  endtask

  task automatic test_reset_mid_packet();
    int s0, e0, b0;
    pkt_bytes = {8'($urandom), 8'($urandom), 8'($urandom)};
    bytes_to_bits();
    encode(1'b1, 4, 4);
    tx_run(4.0, 1'b0, 4 + 8 + 14);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({rx_pkt_start, rx_data, rx_data_put, rx_pkt_end, rx_pkt_valid, rx_bitstuff_err, rx_bus_reset} !== 14'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b want all zero", {rx_pkt_start, rx_data, rx_data_put, rx_pkt_end, rx_pkt_valid, rx_bitstuff_err, rx_bus_reset});
    end
    drive(S_J);
    repeat (5) @(negedge clk_48mhz);
    s0 = n_start; e0 = n_end; b0 = got_bytes.size();
    reset = 1'b0;
    repeat (60) @(negedge clk_48mhz);
    n_cmp++; if (n_end - e0 !== 0 || n_start - s0 !== 0 || got_bytes.size() - b0 !== 0) begin
      n_fail++; $display("FAIL midreset_silent: got ends=%0d starts=%0d bytes=%0d want 0/0/0", n_end - e0, n_start - s0, got_bytes.size() - b0);
    end
    $display("test_reset_mid_packet: done");
  endtask

  initial begin
    test_reset();
    test_in_token();
    test_stuffing();
    test_bitstuff_err();
    test_jitter();
    test_partial();
    test_random();
    test_back_to_back();
    test_bus_reset();
    test_bus_reset_mid_packet();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
